// File: rtl/game_pkg.sv
// Shared types and constants for the reaction-game round controller.
package game_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR,
        ST_WAIT,
        ST_WINDOW,
        ST_HIT,
        ST_MISS,
        ST_FOUL,
        ST_GAP,
        ST_DONE
    } game_state_t;

    localparam int         TICK_W         = 5;
    localparam logic [7:0] LFSR_SEED      = 8'h01;
    // Fibonacci taps 8,6,5,4 (bit 7 is tap 8)
    localparam logic [7:0] LFSR_TAPS      = 8'hB8;
    localparam int         RAND_DELAY_MIN = 4;

    function automatic logic lfsr_feedback(input logic [7:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; a held input
// produces a single one-cycle pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // shift the raw input through the synchronizer and history stage
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // synchronizer and history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/game_round_ctrl.sv
// Round controller for the reaction game: sequences ROUNDS rounds of
// pre-delay, lit target window and inter-round gap, and pulses the score
// counter on hits and at game start.
// Optional macro GAME_RAND_DELAY_EN: pre-delay drawn from an 8-bit LFSR
// (4..19 ticks) instead of DELAY_TICKS.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | after reset, waiting for start
// ST_CLR    | one cycle, clears score, arms round 1
// ST_WAIT   | pre-target delay; a press here is a foul
// ST_WINDOW | target lit, waiting for the press
// ST_HIT    | one cycle, score increment
// ST_MISS   | one cycle, window expired
// ST_FOUL   | one cycle, early press
// ST_GAP    | pause between rounds
// ST_DONE   | game over, final round number held
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int DELAY_TICKS  = 8,
    parameter int WINDOW_TICKS = 4,
    parameter int GAP_TICKS    = 4,
    parameter int ROUNDS       = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       btn,
    input  logic       qsec,
    output logic       score_inc,
    output logic       score_clr,
    output logic       target,
    output logic       foul,
    output logic       done,
    output logic [3:0] round_num
);

    logic start_e;
    logic btn_e;

    btn_sync_edge u_start_sync (
        .clk   (clk),
        .rst_n (reset),
        .din   (start),
        .pulse (start_e)
    );

    btn_sync_edge u_btn_sync (
        .clk   (clk),
        .rst_n (reset),
        .din   (btn),
        .pulse (btn_e)
    );

    logic [TICK_W-1:0] delay_load;

`ifdef GAME_RAND_DELAY_EN
    logic [7:0] lfsr_q, lfsr_d;

    // free-running LFSR, advances every clock
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_feedback(lfsr_q)};
    end

    // LFSR register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign delay_load = TICK_W'(RAND_DELAY_MIN) + {1'b0, lfsr_q[3:0]};
`else
    assign delay_load = TICK_W'(DELAY_TICKS);
`endif

    game_state_t       state_q, state_d;
    logic [TICK_W-1:0] cnt_q, cnt_d;
    logic [3:0]        round_q, round_d;
    logic              tick_last;
    logic [TICK_W-1:0] cnt_dec;

    // expiry is the qsec that takes the counter to zero
    assign tick_last = qsec && (cnt_q <= TICK_W'(1));
    assign cnt_dec   = qsec ? (cnt_q - TICK_W'(1)) : cnt_q;

    // next-state, counter and round logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE: begin
                if (start_e) state_d = ST_CLR;
            end
            ST_CLR: begin
                round_d = 4'd1;
                cnt_d   = delay_load;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (btn_e) begin
                    state_d = ST_FOUL;
                end else if (tick_last) begin
                    state_d = ST_WINDOW;
                    cnt_d   = TICK_W'(WINDOW_TICKS);
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_WINDOW: begin
                if (btn_e) begin
                    state_d = ST_HIT;
                end else if (tick_last) begin
                    state_d = ST_MISS;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_HIT, ST_MISS, ST_FOUL: begin
                state_d = ST_GAP;
                cnt_d   = TICK_W'(GAP_TICKS);
            end
            ST_GAP: begin
                if (tick_last) begin
                    if (round_q == 4'(ROUNDS)) begin
                        state_d = ST_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                        cnt_d   = delay_load;
                        state_d = ST_WAIT;
                    end
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_DONE: begin
                if (start_e) state_d = ST_CLR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state, tick counter and round registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
        end
    end

    // outputs decoded from state so reset clears them immediately
    always_comb begin
        score_inc = (state_q == ST_HIT);
        score_clr = (state_q == ST_CLR);
        target    = (state_q == ST_WINDOW);
        foul      = (state_q == ST_FOUL);
        done      = (state_q == ST_DONE);
        round_num = round_q;
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl (fixed-delay build, ROUNDS=3): a stimulus table,
// directed corner sequences and a random run against a phase-level model.
module tb_game_round_ctrl;

    localparam int DELAY = 8;
    localparam int WIN   = 4;
    localparam int GAP   = 4;
    localparam int NR    = 3;

    logic       clk = 1'b0;
    logic       reset, start, btn, qsec;
    logic       score_inc, score_clr, target, foul, done;
    logic [3:0] round_num;
    logic [8:0] dut_out;

    always #5 clk = ~clk;

    game_round_ctrl #(
        .DELAY_TICKS (DELAY),
        .WINDOW_TICKS(WIN),
        .GAP_TICKS   (GAP),
        .ROUNDS      (NR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .btn      (btn),
        .qsec     (qsec),
        .score_inc(score_inc),
        .score_clr(score_clr),
        .target   (target),
        .foul     (foul),
        .done     (done),
        .round_num(round_num)
    );

    assign dut_out = {score_inc, score_clr, target, foul, done, round_num};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- phase-level reference model ----------------
    localparam int P_IDLE = 0, P_CLR = 1, P_WAIT = 2, P_WIN = 3, P_HIT = 4,
                   P_MISS = 5, P_FOUL = 6, P_GAP = 7, P_DONE = 8;

    int       m_phase, m_seen, m_round;
    logic [2:0] s_h, b_h;   // raw button samples, [0] newest

    task automatic model_reset();
        m_phase = P_IDLE; m_seen = 0; m_round = 0;
        s_h = '0; b_h = '0;
    endtask

    // called once per rising edge with the inputs present at that edge
    task automatic model_step(input logic s, input logic b, input logic q);
        logic se, be;
        se = s_h[1] & ~s_h[2];
        be = b_h[1] & ~b_h[2];
        s_h = {s_h[1:0], s};
        b_h = {b_h[1:0], b};
        case (m_phase)
            P_IDLE, P_DONE: if (se) m_phase = P_CLR;
            P_CLR: begin m_phase = P_WAIT; m_round = 1; m_seen = 0; end
            P_WAIT, P_WIN: begin
                if (be) m_phase = (m_phase == P_WAIT) ? P_FOUL : P_HIT;
                else if (q) begin
                    m_seen++;
                    if (m_seen == ((m_phase == P_WAIT) ? DELAY : WIN)) begin
                        m_phase = (m_phase == P_WAIT) ? P_WIN : P_MISS;
                        m_seen  = 0;
                    end
                end
            end
            P_HIT, P_MISS, P_FOUL: begin m_phase = P_GAP; m_seen = 0; end
            P_GAP: if (q) begin
                m_seen++;
                if (m_seen == GAP) begin
                    m_seen = 0;
                    if (m_round == NR) m_phase = P_DONE;
                    else begin m_round++; m_phase = P_WAIT; end
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    function automatic logic [8:0] model_out();
        return {m_phase == P_HIT, m_phase == P_CLR, m_phase == P_WIN,
                m_phase == P_FOUL, m_phase == P_DONE, 4'(m_round)};
    endfunction

    // ---------------- stimulus helpers ----------------
    int   n_inc = 0, n_clr = 0;
    logic seen_tgt = 1'b0;

    task automatic tick(input logic s, input logic b, input logic q);
        start = s; btn = b; qsec = q;
        @(posedge clk);
        model_step(s, b, q);
        @(negedge clk);
        check("model", dut_out, model_out());
        n_inc += int'(score_inc);
        n_clr += int'(score_clr);
        seen_tgt |= target;
    endtask

    task automatic q_ticks(input int n, input logic b);
        for (int i = 0; i < n; i++) tick(1'b0, b, 1'b1);
    endtask

    typedef struct {
        logic       s, b, q;
        logic [8:0] exp;   // {inc, clr, target, foul, done, round[3:0]}
    } vec_t;

    vec_t tbl[18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, c0, game_inc, max_inc;
        logic s_lv, b_lv, q_lv;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 9'h000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 9'h000};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 9'h080};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 9'h001};
        for (int i = 4; i <= 10; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 9'h001};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 9'h041};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 9'h041};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 9'h041};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 9'h041};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 9'h041};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 9'h101};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 9'h001};

        reset = 1'b0; start = 1'b0; btn = 1'b0; qsec = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_state", dut_out, 9'h000);
        reset = 1'b1;

        // start latency, 8-tick wait, press two ticks into the window
        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].s, tbl[i].b, tbl[i].q);
            check($sformatf("vec%0d", i), dut_out, tbl[i].exp);
        end
        check("clr_count", n_clr, 1);
        check("inc_count", n_inc, 1);

        q_ticks(3, 1'b0);
        check("gap_hold_round", round_num, 4'd1);
        q_ticks(1, 1'b0);
        check("gap_next_round", round_num, 4'd2);

        // press lands on the final WAIT qsec: foul wins
        seen_tgt = 1'b0; n0 = n_inc;
        q_ticks(7, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        check("foul_on_last_tick", foul, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        check("foul_one_cycle", foul, 1'b0);
        check("foul_no_target", seen_tgt, 1'b0);
        check("foul_no_inc", n_inc - n0, 0);
        q_ticks(4, 1'b0);
        check("round3", round_num, 4'd3);

        // press lands on the final WINDOW qsec: hit wins
        q_ticks(8, 1'b0);
        check("window_lit", target, 1'b1);
        q_ticks(3, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        check("hit_on_last_tick", score_inc, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        q_ticks(4, 1'b0);
        check("done_after_last", {done, round_num}, {1'b1, 4'd3});

        // restart from DONE, three missed rounds
        tick(1'b1, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0);
        check("restart_clr", score_clr, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        n0 = n_inc;
        for (int r = 0; r < NR; r++) begin
            q_ticks(8, 1'b0);
            q_ticks(4, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
            q_ticks(4, 1'b0);
        end
        check("miss_game_done", {done, round_num}, {1'b1, 4'd3});
        check("miss_game_no_inc", n_inc - n0, 0);
        tick(1'b1, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0);
        check("rearm_clr", score_clr, 1'b1);
        tick(1'b0, 1'b0, 1'b0);

        // start pressed during WAIT is ignored
        c0 = n_clr;
        tick(1'b1, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0);
        check("start_in_wait_clr", n_clr - c0, 0);
        check("start_in_wait_round", {done, round_num}, {1'b0, 4'd1});

        // button held across two windows scores once
        q_ticks(8, 1'b0);
        n0 = n_inc;
        tick(1'b0, 1'b1, 1'b0); tick(1'b0, 1'b1, 1'b0); tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        q_ticks(4, 1'b1);
        q_ticks(8, 1'b1);
        q_ticks(4, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        check("held_btn_one_inc", n_inc - n0, 1);

        // asynchronous reset in the middle of a window
        q_ticks(4, 1'b0);
        q_ticks(8, 1'b0);
        check("pre_reset_target", target, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rst_async_target", target, 1'b0);
        check("rst_async_inc", score_inc, 1'b0);
        model_reset();
        start = 1'b0; btn = 1'b0; qsec = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        c0 = n_clr; n0 = n_inc;
        tick(1'b0, 1'b0, 1'b1); tick(1'b0, 1'b0, 1'b0);
        check("post_reset_idle", dut_out, 9'h000);
        check("post_reset_no_pulse", (n_clr - c0) + (n_inc - n0), 0);

        // random run against the model
        s_lv = 1'b0; b_lv = 1'b0; game_inc = 0; max_inc = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(39) == 0) s_lv = ~s_lv;
            if ($urandom_range(5) == 0)  b_lv = ~b_lv;
            q_lv = ($urandom_range(2) == 0);
            tick(s_lv, b_lv, q_lv);
            if (score_clr) game_inc = 0;
            if (score_inc) game_inc++;
            if (game_inc > max_inc) max_inc = game_inc;
        end
        check("inc_per_game_bound", max_inc <= NR, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
